// File: rtl/uart_icb_seq.sv
// -----------------------------------------------------------------------------
// uart_icb_seq
//
// ICB master that drives the gjy_uart_top register slave on behalf of a byte
// stream. On start it writes a configuration word to CTRL, then accepts bytes
// on a valid/ready stream, writes each to DATA_TX and polls CSR until the
// byte has gone out. With receive support compiled in, CSR polling also
// drains DATA_RX into a one-cycle output pulse stream.
//
// Build option:
//   UART_SEQ_RX_EN  - when defined, the RX drain path is built and the
//                     sequencer polls CSR continuously while no byte is
//                     waiting to be sent. When undefined, rx_valid/rx_data
//                     are tied to 0 and WAIT_TX simply waits for tx_valid.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse, starts configuration from IDLE and
//                     clears err
//   cfg_ctrl[31:0]    word written to CTRL_ADDR, sampled on start
//   tx_valid/tx_ready/tx_data[7:0]
//                     byte input stream; tx_ready is high only in WAIT_TX
//   rx_valid/rx_data[7:0]
//                     received byte, one-cycle pulse, no backpressure
//   busy              high in every state except IDLE
//   err               sticky CSR poll timeout flag
//   o_icb_cmd_*       ICB command channel (registered, held until accepted)
//   o_icb_rsp_*       ICB response channel
// -----------------------------------------------------------------------------
module uart_icb_seq #(
    parameter logic [31:0] CTRL_ADDR   = 32'h0000_0004,
    parameter logic [31:0] CSR_ADDR    = 32'h0000_0000,
    parameter logic [31:0] TX_ADDR     = 32'h0000_0008,
    parameter logic [31:0] RX_ADDR     = 32'h0000_000C,
    parameter int          TX_DONE_BIT = 1,
    parameter int          RX_DONE_BIT = 0,
    parameter int          POLL_GAP    = 64,
    parameter int          POLL_MAX    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] cfg_ctrl,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        busy,
    output logic        err,
    output logic        o_icb_cmd_valid,
    input  logic        o_icb_cmd_ready,
    output logic [31:0] o_icb_cmd_addr,
    output logic        o_icb_cmd_read,
    output logic [31:0] o_icb_cmd_wdata,
    input  logic        o_icb_rsp_valid,
    output logic        o_icb_rsp_ready,
    input  logic [31:0] o_icb_rsp_rdata
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_CMD,
        S_CFG_RSP,
        S_WAIT_TX,
        S_TX_CMD,
        S_TX_RSP,
        S_GAP,
        S_POLL_CMD,
        S_POLL_RSP
`ifdef UART_SEQ_RX_EN
        ,
        S_RX_CMD,
        S_RX_RSP
`endif
    } state_t;

    localparam logic [15:0] GAP_LAST   = 16'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] gap_cnt;
    logic [15:0] poll_cnt;
    logic [15:0] poll_cnt_inc;
    logic        poll_timeout;
    logic        cmd_fire;
    logic        rsp_fire;
    logic        rsp_tx_done;
    logic        unused_rdata;

    assign cmd_fire     = o_icb_cmd_valid && o_icb_cmd_ready;
    assign rsp_fire     = o_icb_rsp_valid && o_icb_rsp_ready;
    assign rsp_tx_done  = o_icb_rsp_rdata[TX_DONE_BIT];
    // Only a few read-data bits are meaningful to the sequencer.
    assign unused_rdata = ^o_icb_rsp_rdata;

    // Saturating increment; the timeout compare uses the post-increment value
    // so that the POLL_MAX-th unsuccessful poll is the one that gives up.
    assign poll_cnt_inc = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
    assign poll_timeout = (poll_cnt_inc >= POLL_LIMIT);

`ifdef UART_SEQ_RX_EN
    logic rsp_rx_avail;
    // Set while a byte written to DATA_TX has not yet reported TX_DONE; polls
    // made while idle only look for received data and never time out.
    logic tx_busy;
    // TX_DONE observed on the poll that also found RX data; decides where the
    // RX drain returns to.
    logic tx_done_pend;

    assign rsp_rx_avail = o_icb_rsp_rdata[RX_DONE_BIT];
`else
    logic unused_rx_cfg;
    assign unused_rx_cfg = (^RX_ADDR) ^ (RX_DONE_BIT != 0);
    assign rx_valid      = 1'b0;
    assign rx_data       = 8'h00;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every path must assign state_nxt; the default here keeps
        // always_comb from inferring a latch for the hold case.
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_CFG_CMD;
            S_CFG_CMD:  if (cmd_fire) state_nxt = S_CFG_RSP;
            S_CFG_RSP:  if (rsp_fire) state_nxt = S_WAIT_TX;
            S_WAIT_TX: begin
                if (tx_valid) begin
                    state_nxt = S_TX_CMD;
                end
`ifdef UART_SEQ_RX_EN
                else begin
                    state_nxt = S_GAP;
                end
`endif
            end
            S_TX_CMD:   if (cmd_fire) state_nxt = S_TX_RSP;
            S_TX_RSP:   if (rsp_fire) state_nxt = S_GAP;
            S_GAP:      if (gap_cnt == GAP_LAST) state_nxt = S_POLL_CMD;
            S_POLL_CMD: if (cmd_fire) state_nxt = S_POLL_RSP;
            S_POLL_RSP: begin
                if (rsp_fire) begin
`ifdef UART_SEQ_RX_EN
                    if (rsp_rx_avail) begin
                        state_nxt = S_RX_CMD;
                    end else if (rsp_tx_done || !tx_busy) begin
                        state_nxt = S_WAIT_TX;
                    end else
`else
                    if (rsp_tx_done) begin
                        state_nxt = S_WAIT_TX;
                    end else
`endif
                    if (poll_timeout) begin
                        state_nxt = S_WAIT_TX;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end
            end
`ifdef UART_SEQ_RX_EN
            S_RX_CMD:   if (cmd_fire) state_nxt = S_RX_RSP;
            S_RX_RSP: begin
                if (rsp_fire) state_nxt = tx_done_pend ? S_WAIT_TX : S_GAP;
            end
`endif
            default:    state_nxt = S_IDLE;
        endcase
    end

    assign tx_ready        = (state == S_WAIT_TX);
    assign busy            = (state != S_IDLE);
    assign o_icb_rsp_ready = (state == S_CFG_RSP) || (state == S_TX_RSP) ||
`ifdef UART_SEQ_RX_EN
                             (state == S_RX_RSP) ||
`endif
                             (state == S_POLL_RSP);

    // -------------------------------------------------------------------------
    // State register and ICB command channel. The command is loaded on entry
    // to a *_CMD state, so address/data are stable from the first cycle
    // cmd_valid is seen and stay put until the handshake.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            o_icb_cmd_valid <= 1'b0;
            o_icb_cmd_addr  <= 32'h0;
            o_icb_cmd_read  <= 1'b0;
            o_icb_cmd_wdata <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments throughout sequential logic, so
            // every register here sees the pre-edge values of the others.
            state <= state_nxt;
            if (cmd_fire) begin
                o_icb_cmd_valid <= 1'b0;
            end
            if (state_nxt != state) begin
                case (state_nxt)
                    S_CFG_CMD: begin
                        o_icb_cmd_valid <= 1'b1;
                        o_icb_cmd_addr  <= CTRL_ADDR;
                        o_icb_cmd_read  <= 1'b0;
                        o_icb_cmd_wdata <= cfg_ctrl;
                    end
                    S_TX_CMD: begin
                        o_icb_cmd_valid <= 1'b1;
                        o_icb_cmd_addr  <= TX_ADDR;
                        o_icb_cmd_read  <= 1'b0;
                        o_icb_cmd_wdata <= {24'h0, tx_data};
                    end
                    S_POLL_CMD: begin
                        o_icb_cmd_valid <= 1'b1;
                        o_icb_cmd_addr  <= CSR_ADDR;
                        o_icb_cmd_read  <= 1'b1;
                        o_icb_cmd_wdata <= 32'h0;
                    end
`ifdef UART_SEQ_RX_EN
                    S_RX_CMD: begin
                        o_icb_cmd_valid <= 1'b1;
                        o_icb_cmd_addr  <= RX_ADDR;
                        o_icb_cmd_read  <= 1'b1;
                        o_icb_cmd_wdata <= 32'h0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Gap timer, poll counter and error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt  <= 16'h0;
            poll_cnt <= 16'h0;
            err      <= 1'b0;
        end else begin
            if (state == S_GAP && gap_cnt != GAP_LAST) begin
                gap_cnt <= gap_cnt + 16'd1;
            end else begin
                gap_cnt <= 16'h0;
            end

            if (state == S_TX_RSP && rsp_fire) begin
                poll_cnt <= 16'h0;
            end else if (state == S_POLL_RSP && rsp_fire &&
                         state_nxt == S_GAP) begin
                poll_cnt <= poll_cnt_inc;
            end

            // start clears err in any state (the FSM itself only reacts to
            // start in IDLE); a timeout in the same cycle wins so it is
            // never lost.
            if (state == S_POLL_RSP && rsp_fire && state_nxt == S_WAIT_TX &&
                !rsp_tx_done
`ifdef UART_SEQ_RX_EN
                && tx_busy
`endif
               ) begin
                err <= 1'b1;
            end else if (start) begin
                err <= 1'b0;
            end
        end
    end

`ifdef UART_SEQ_RX_EN
    // -------------------------------------------------------------------------
    // RX drain output and TX bookkeeping
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid     <= 1'b0;
            rx_data      <= 8'h00;
            tx_busy      <= 1'b0;
            tx_done_pend <= 1'b0;
        end else begin
            rx_valid <= (state == S_RX_RSP) && rsp_fire;
            if (state == S_RX_RSP && rsp_fire) begin
                rx_data <= o_icb_rsp_rdata[7:0];
            end

            if (state == S_WAIT_TX && tx_valid) begin
                tx_busy <= 1'b1;
            end else if (state_nxt == S_WAIT_TX) begin
                tx_busy <= 1'b0;
            end

            // With no byte in flight, a drain returns straight to WAIT_TX.
            if (state == S_POLL_RSP && rsp_fire && rsp_rx_avail) begin
                tx_done_pend <= rsp_tx_done || !tx_busy;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_icb_seq.sv
module tb_uart_icb_seq;

    localparam int          GAP    = 4;
    localparam int          PMAX   = 4;
    localparam logic [31:0] CTRL_A = 32'h0000_0004;
    localparam logic [31:0] CSR_A  = 32'h0000_0000;
    localparam logic [31:0] TX_A   = 32'h0000_0008;
    localparam logic [31:0] RX_A   = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_ctrl = 32'h0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  tx_data = 8'h00;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;
    logic        err;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_rdata = 32'h0;

    uart_icb_seq #(.POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_ctrl        (cfg_ctrl),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_data         (tx_data),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .busy            (busy),
        .err             (err),
        .o_icb_cmd_valid (cmd_valid),
        .o_icb_cmd_ready (cmd_ready),
        .o_icb_cmd_addr  (cmd_addr),
        .o_icb_cmd_read  (cmd_read),
        .o_icb_cmd_wdata (cmd_wdata),
        .o_icb_rsp_valid (rsp_valid),
        .o_icb_rsp_ready (rsp_ready),
        .o_icb_rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    // ICB slave model state and command log
    int          stall      = 0;
    int          wait_cnt   = 0;
    int          done_after = 0;
    int          csr_polls  = 0;
    bit          lb_en      = 1'b0;
    bit          fire_cmd   = 1'b0;
    bit          fire_rsp   = 1'b0;
    logic [31:0] rdata_nxt  = 32'h0;
    logic [7:0]  rxq[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    bit          log_read[$];
    int          log_cyc[$];

    // Monitor state
    bit          m_valid = 1'b0;
    logic [31:0] m_addr, m_wdata;
    bit          m_read;
    bit          m_rx = 1'b0;
    int          stab_err = 0;
    int          dup_err  = 0;
    int          rx_hi    = 0;
    int          rx_long  = 0;
    logic [7:0]  rx_seen[$];

    // Slave and monitor run at the falling edge so every input change is
    // half a period away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            cmd_ready = 1'b0;
            rsp_valid = 1'b0;
            rsp_rdata = 32'h0;
            fire_cmd  = 1'b0;
            fire_rsp  = 1'b0;
            wait_cnt  = 0;
            m_valid   = 1'b0;
            m_rx      = 1'b0;
        end else begin
            // cmd_ready still holds the value seen at the edge just passed.
            if (m_valid && !cmd_ready &&
                (!cmd_valid || cmd_addr !== m_addr || cmd_read !== m_read ||
                 cmd_wdata !== m_wdata))
                stab_err++;
            if (m_valid && cmd_ready && cmd_valid) dup_err++;
            m_valid = cmd_valid;
            m_addr  = cmd_addr;
            m_read  = cmd_read;
            m_wdata = cmd_wdata;
            if (rx_valid) begin
                rx_hi++;
                rx_seen.push_back(rx_data);
                if (m_rx) rx_long++;
            end
            m_rx = rx_valid;

            if (fire_rsp) rsp_valid = 1'b0;
            if (fire_cmd) begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_nxt;
            end
            fire_cmd = 1'b0;
            if (cmd_valid) begin
                if (wait_cnt >= stall) begin
                    cmd_ready = 1'b1;
                    fire_cmd  = 1'b1;
                    wait_cnt  = 0;
                    log_addr.push_back(cmd_addr);
                    log_wdata.push_back(cmd_wdata);
                    log_read.push_back(cmd_read);
                    log_cyc.push_back(cyc + 1);
                    rdata_nxt = 32'h0;
                    if (cmd_read && cmd_addr == CSR_A) begin
                        csr_polls++;
                        if (done_after != 0 && csr_polls >= done_after) rdata_nxt[1] = 1'b1;
                        if (rxq.size() > 0) rdata_nxt[0] = 1'b1;
                    end else if (cmd_read && cmd_addr == RX_A) begin
                        if (rxq.size() > 0) rdata_nxt[7:0] = rxq.pop_front();
                    end else if (!cmd_read && cmd_addr == TX_A) begin
                        csr_polls = 0;
                        if (lb_en) rxq.push_back(cmd_wdata[7:0]);
                    end
                end else begin
                    cmd_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                cmd_ready = 1'b0;
            end
            fire_rsp = rsp_valid && rsp_ready;
        end
    end

    function automatic int count_ctrl_writes();
        int n = 0;
        foreach (log_addr[i]) if (log_addr[i] == CTRL_A && !log_read[i]) n++;
        return n;
    endfunction

    task automatic pulse_start(input logic [31:0] cfg);
        @(negedge clk);
        cfg_ctrl = cfg;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_ready(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns with tx_valid dropped; mark is the log index of the TX write and
    // acc the cycle number of the accepting edge.
    task automatic send_byte(input logic [7:0] b, output int mark, output int acc,
                             output bit ok);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        mark = log_addr.size();
        acc  = cyc + 1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        int mark;
        bit ok;
        repeat (3) @(negedge clk);
        n_total++;
        if ({tx_ready, rx_valid, rx_data, busy, err, cmd_valid, cmd_addr, cmd_read,
             cmd_wdata, rsp_ready} !== '0)
            $display("FAIL reset_outputs: some output nonzero during reset");
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b cmd_valid=%b want 0/0", busy, cmd_valid);
        else n_pass++;
        mark = log_addr.size();
        pulse_start(32'h0034_1111);
        wait_ready(50, ok);
        n_total++;
        if (!ok) $display("FAIL cfg_ready: tx_ready not seen"); else n_pass++;
        n_total++;
        if (log_addr.size() - mark !== 1)
            $display("FAIL cfg_cmd_count: got %0d want 1", log_addr.size() - mark);
        else n_pass++;
        n_total++;
        if (log_addr[mark] !== CTRL_A || log_read[mark] !== 1'b0)
            $display("FAIL cfg_addr: got %h read=%b want %h write", log_addr[mark],
                     log_read[mark], CTRL_A);
        else n_pass++;
        n_total++;
        if (log_wdata[mark] !== 32'h0034_1111)
            $display("FAIL cfg_wdata: got %h want 00341111", log_wdata[mark]);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1 || err !== 1'b0)
            $display("FAIL cfg_status: busy=%b err=%b want 1/0", busy, err);
        else n_pass++;
    endtask

    task automatic test_tx_poll();
        int mark, acc;
        bit ok;
        done_after = 3;
        send_byte(8'hA5, mark, acc, ok);
        n_total++;
        if (!ok) $display("FAIL tx_accept: tx_ready not seen"); else n_pass++;
        wait_ready(200, ok);
        n_total++;
        if (!ok) $display("FAIL tx_done_ready: tx_ready not back"); else n_pass++;
        n_total++;
        if (log_addr.size() - mark !== 4)
            $display("FAIL tx_cmd_count: got %0d want 4", log_addr.size() - mark);
        else n_pass++;
        n_total++;
        if (log_addr[mark] !== TX_A || log_read[mark] !== 1'b0 ||
            log_wdata[mark] !== 32'h0000_00A5)
            $display("FAIL tx_write: addr=%h read=%b wdata=%h want %h 0 000000a5",
                     log_addr[mark], log_read[mark], log_wdata[mark], TX_A);
        else n_pass++;
        n_total++;
        if (log_cyc[mark] - acc !== 1)
            $display("FAIL tx_latency: got %0d want 1", log_cyc[mark] - acc);
        else n_pass++;
        n_total++;
        if (log_cyc[mark + 1] - acc !== GAP + 3)
            $display("FAIL first_poll_latency: got %0d want %0d", log_cyc[mark + 1] - acc,
                     GAP + 3);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            n_total++;
            if (log_addr[mark + i] !== CSR_A || log_read[mark + i] !== 1'b1)
                $display("FAIL poll%0d_cmd: addr=%h read=%b want %h 1", i,
                         log_addr[mark + i], log_read[mark + i], CSR_A);
            else n_pass++;
        end
        for (int i = 2; i <= 3; i++) begin
            n_total++;
            if (log_cyc[mark + i] - log_cyc[mark + i - 1] !== GAP + 2)
                $display("FAIL poll%0d_spacing: got %0d want %0d", i,
                         log_cyc[mark + i] - log_cyc[mark + i - 1], GAP + 2);
            else n_pass++;
        end
        n_total++;
        if (err !== 1'b0) $display("FAIL tx_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_stall();
        int mark, acc;
        bit ok;
        stab_err   = 0;
        dup_err    = 0;
        done_after = 1;
        stall      = 5;
        send_byte(8'h3C, mark, acc, ok);
        wait_ready(300, ok);
        stall = 0;
        n_total++;
        if (!ok) $display("FAIL stall_ready: tx_ready not back"); else n_pass++;
        n_total++;
        if (stab_err !== 0)
            $display("FAIL stall_stable: got %0d unstable cycles want 0", stab_err);
        else n_pass++;
        n_total++;
        if (dup_err !== 0) $display("FAIL stall_dup: got %0d want 0", dup_err); else n_pass++;
        n_total++;
        if (log_addr.size() - mark !== 2)
            $display("FAIL stall_cmd_count: got %0d want 2", log_addr.size() - mark);
        else n_pass++;
        n_total++;
        if (log_wdata[mark] !== 32'h0000_003C || log_addr[mark + 1] !== CSR_A)
            $display("FAIL stall_cmds: wdata=%h poll_addr=%h want 0000003c %h",
                     log_wdata[mark], log_addr[mark + 1], CSR_A);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int mark, acc, ctrl_before;
        bit ok;
        done_after = 0;
        send_byte(8'h5A, mark, acc, ok);
        wait_ready(500, ok);
        n_total++;
        if (!ok) $display("FAIL timeout_ready: tx_ready not back"); else n_pass++;
        n_total++;
        if (log_addr.size() - mark - 1 !== PMAX)
            $display("FAIL timeout_polls: got %0d want %0d", log_addr.size() - mark - 1, PMAX);
        else n_pass++;
        n_total++;
        if (err !== 1'b1) $display("FAIL timeout_err: got %b want 1", err); else n_pass++;
        ctrl_before = count_ctrl_writes();
        pulse_start(32'hDEAD_BEEF);
        n_total++;
        if (err !== 1'b0) $display("FAIL start_clears_err: got %b want 0", err); else n_pass++;
        repeat (20) @(negedge clk);
        n_total++;
        if (count_ctrl_writes() !== ctrl_before || busy !== 1'b1)
            $display("FAIL start_ignored: ctrl writes %0d want %0d busy=%b",
                     count_ctrl_writes(), ctrl_before, busy);
        else n_pass++;
    endtask

    task automatic test_rx();
`ifdef UART_SEQ_RX_EN
        logic [7:0] bytes[3] = '{8'h11, 8'h23, 8'hFF};
        int mark0, mark, acc, nrx;
        bit ok;
        wait_ready(200, ok);
        lb_en      = 1'b1;
        done_after = 1;
        rx_seen.delete();
        rx_long = 0;
        mark0   = log_addr.size();
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i], mark, acc, ok);
            wait_ready(300, ok);
            n_total++;
            if (!ok) $display("FAIL rx_byte%0d_ready: tx_ready not back", i); else n_pass++;
        end
        lb_en = 1'b0;
        nrx   = 0;
        for (int i = mark0; i < log_addr.size(); i++)
            if (log_addr[i] == RX_A && log_read[i]) nrx++;
        n_total++;
        if (nrx !== 3) $display("FAIL rx_reads: got %0d want 3", nrx); else n_pass++;
        n_total++;
        if (rx_seen.size() !== 3)
            $display("FAIL rx_pulses: got %0d want 3", rx_seen.size());
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (i >= rx_seen.size() || rx_seen[i] !== bytes[i])
                $display("FAIL rx_data%0d: got %h want %h", i,
                         (i < rx_seen.size()) ? rx_seen[i] : 8'hxx, bytes[i]);
            else n_pass++;
        end
        n_total++;
        if (rx_long !== 0) $display("FAIL rx_pulse_width: got %0d long pulses want 0", rx_long);
        else n_pass++;
`else
        n_total++;
        if (rx_hi !== 0 || rx_data !== 8'h00)
            $display("FAIL rx_tied_off: rx_valid seen %0d times, rx_data=%h want 0/00",
                     rx_hi, rx_data);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        int mark, acc, size_at_rst;
        bit ok, found;
        done_after = 0;
        wait_ready(200, ok);
        send_byte(8'h77, mark, acc, ok);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_ready && log_addr.size() == mark + 1) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (!found) $display("FAIL reach_tx_rsp: TX_RSP not observed"); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if ({tx_ready, rx_valid, rx_data, busy, err, cmd_valid, cmd_addr, cmd_read,
             cmd_wdata, rsp_ready} !== '0)
            $display("FAIL mid_reset_outputs: some output nonzero in reset");
        else n_pass++;
        size_at_rst = log_addr.size();
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || tx_ready !== 1'b0 || log_addr.size() !== size_at_rst)
            $display("FAIL mid_reset_idle: busy=%b tx_ready=%b new cmds=%0d want 0/0/0",
                     busy, tx_ready, log_addr.size() - size_at_rst);
        else n_pass++;
        mark = log_addr.size();
        pulse_start(32'h0000_0ABC);
        wait_ready(50, ok);
        n_total++;
        if (!ok || log_addr.size() <= mark || log_addr[mark] !== CTRL_A ||
            log_wdata[mark] !== 32'h0000_0ABC)
            $display("FAIL restart_cfg: ready=%b addr=%h wdata=%h want 1 %h 00000abc", ok,
                     (log_addr.size() > mark) ? log_addr[mark] : 32'hx,
                     (log_addr.size() > mark) ? log_wdata[mark] : 32'hx, CTRL_A);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tx_poll();
        test_stall();
        test_timeout();
        test_rx();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
